// File: rtl/ldtu_stream_decoder_if.sv
// rtl/ldtu_stream_decoder_if.sv - word input, sample output and status bundle of the LiTe-DTU stream decoder
interface ldtu_stream_decoder_if #(
    parameter int NBITS_SAMPLE = 13,
    parameter int ERR_CNT_W    = 8
);
    logic [31:0]             in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [NBITS_SAMPLE-1:0] out_sample;
    logic                    out_baseline;
    logic                    out_valid;
    logic                    out_ready;
    logic                    orbit_pulse;
    logic                    sync_pulse;
    logic                    err_pulse;
    logic [ERR_CNT_W-1:0]    err_count;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sample, out_baseline, out_valid,
               orbit_pulse, sync_pulse, err_pulse, err_count
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sample, out_baseline, out_valid,
               orbit_pulse, sync_pulse, err_pulse, err_count
    );
endinterface

// File: rtl/ldtu_stream_decoder.sv
// rtl/ldtu_stream_decoder.sv - unpacks LiTe-DTU normal-mode words into a one-sample-per-cycle stream
module ldtu_stream_decoder #(
    parameter int          NBITS_SAMPLE = 13,
    parameter int          NBITS_BAS    = 6,
    parameter int          ERR_CNT_W    = 8,
    parameter logic [31:0] IDLE_WORD    = 32'hF000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    ldtu_stream_decoder_if.slave  bus
);
    localparam logic [12:0] HDR_PATTERN  = 13'b1111000001111;
    localparam logic [12:0] SYNC_PATTERN = 13'b0101010101010;

    typedef enum logic {EMPTY, UNPACK} state_t;

    state_t                  state;
    logic [29:0]             word_reg;
    logic                    base_reg;
    logic [2:0]              idx;
    logic [2:0]              last_idx;
    logic [NBITS_SAMPLE-1:0] out_sample;
    logic                    out_baseline;
    logic                    orbit_pulse;
    logic                    sync_pulse;
    logic                    err_pulse;
    logic [ERR_CNT_W-1:0]    err_count;

    logic [2:0] n_new;
    logic       base_new;
    logic       err_new;
    logic       orbit_new;
    logic       sync_new;
    logic       in_ready;
    logic       accept;

    // Sample k of a word: baseline samples are 6-bit lanes, signal samples 13-bit lanes.
    function automatic logic [NBITS_SAMPLE-1:0] sample_of(input logic [29:0] w,
                                                          input logic b,
                                                          input logic [2:0] k);
        logic [29:0] sh;
        if (b) begin
            sh = w >> (NBITS_BAS * int'(k));
            return NBITS_SAMPLE'(sh[NBITS_BAS-1:0]);
        end
        sh = w >> (NBITS_SAMPLE * int'(k));
        return sh[NBITS_SAMPLE-1:0];
    endfunction

    always_comb begin
        n_new     = 3'd0;
        base_new  = 1'b0;
        err_new   = 1'b0;
        orbit_new = 1'b0;
        sync_new  = 1'b0;
        if (bus.in_data == IDLE_WORD) begin
            n_new = 3'd0;
        end else if (bus.in_data[31:30] == 2'b01) begin
            n_new    = 3'd5;
            base_new = 1'b1;
        end else if (bus.in_data[31:30] == 2'b10) begin
            if (bus.in_data[29:24] >= 6'd1 && bus.in_data[29:24] <= 6'd4) begin
                n_new    = bus.in_data[26:24];
                base_new = 1'b1;
            end else begin
                err_new = 1'b1;
            end
        end else if (bus.in_data[31:26] == 6'b001010) begin
            n_new = 3'd2;
        end else if (bus.in_data[31:26] == 6'b001011) begin
            if (bus.in_data[25:13] == HDR_PATTERN) begin
                n_new     = 3'd1;
                orbit_new = 1'b1;
            end else if (bus.in_data[25:13] == SYNC_PATTERN) begin
                n_new    = 3'd1;
                sync_new = 1'b1;
            end else begin
                err_new = 1'b1;
            end
        end else begin
            err_new = 1'b1;
        end
    end

    // Ready during the last presented sample so consecutive words stream without a gap.
    assign in_ready = (state == EMPTY) || (bus.out_ready && idx == last_idx);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= EMPTY;
            word_reg     <= '0;
            base_reg     <= 1'b0;
            idx          <= 3'd0;
            last_idx     <= 3'd0;
            out_sample   <= '0;
            out_baseline <= 1'b0;
            orbit_pulse  <= 1'b0;
            sync_pulse   <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= '0;
        end else begin
            orbit_pulse <= 1'b0;
            sync_pulse  <= 1'b0;
            err_pulse   <= 1'b0;
            if (state == UNPACK && bus.out_ready) begin
                if (idx == last_idx) begin
                    state <= EMPTY;
                end else begin
                    idx        <= idx + 3'd1;
                    out_sample <= sample_of(word_reg, base_reg, idx + 3'd1);
                end
            end
            if (accept) begin
                orbit_pulse <= orbit_new;
                sync_pulse  <= sync_new;
                err_pulse   <= err_new;
                if (err_new && err_count != {ERR_CNT_W{1'b1}})
                    err_count <= err_count + ERR_CNT_W'(1);
                if (n_new != 3'd0) begin
                    state        <= UNPACK;
                    word_reg     <= bus.in_data[29:0];
                    base_reg     <= base_new;
                    idx          <= 3'd0;
                    last_idx     <= n_new - 3'd1;
                    out_sample   <= sample_of(bus.in_data[29:0], base_new, 3'd0);
                    out_baseline <= base_new;
                end
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = (state == UNPACK);
    assign bus.out_sample   = out_sample;
    assign bus.out_baseline = out_baseline;
    assign bus.orbit_pulse  = orbit_pulse;
    assign bus.sync_pulse   = sync_pulse;
    assign bus.err_pulse    = err_pulse;
    assign bus.err_count    = err_count;
endmodule

// File: tb/tb_ldtu_stream_decoder.sv
// tb/tb_ldtu_stream_decoder.sv - directed bench with a queue-based word model for ldtu_stream_decoder
module tb_ldtu_stream_decoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ldtu_stream_decoder_if bus ();
    ldtu_stream_decoder dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit armed = 1'b0;
    bit toggle = 1'b0;

    int exp_val[$];
    bit exp_base[$];
    bit exp_orbit = 0, exp_sync = 0, exp_err = 0;
    int exp_cnt = 0;

    int got[$];
    bit got_base[$];
    int got_cyc[$];
    int orbit_seen = 0, sync_seen = 0, err_seen = 0;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // kinds: 0 idle, 1 baseline, 2 signal pair, 3 error, 4 orbit header, 5 sync
    function automatic int m_kind(input logic [31:0] w);
        int p2, p6, mid, n;
        p2  = int'(w >> 30);
        p6  = int'(w >> 26);
        mid = int'((w >> 13) & 32'h1FFF);
        n   = int'((w >> 24) & 32'h3F);
        if (w == 32'hF000_0000) return 0;
        if (p2 == 1) return 1;
        if (p2 == 2) return (n >= 1 && n <= 4) ? 1 : 3;
        if (p6 == 10) return 2;
        if (p6 == 11) return (mid == 'h1E0F) ? 4 : (mid == 'h0AAA) ? 5 : 3;
        return 3;
    endfunction

    function automatic int m_count(input logic [31:0] w);
        case (m_kind(w))
            1: return (int'(w >> 30) == 1) ? 5 : int'((w >> 24) & 32'h3F);
            2: return 2;
            4, 5: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int m_sample(input logic [31:0] w, input int k);
        if (m_kind(w) == 1) return int'((w >> (6 * k)) & 32'h3F);
        return int'((w >> (13 * k)) & 32'h1FFF);
    endfunction

    task automatic model_accept(input logic [31:0] w);
        int k;
        k = m_kind(w);
        exp_err   = (k == 3);
        exp_orbit = (k == 4);
        exp_sync  = (k == 5);
        if (k == 3 && exp_cnt < 255) exp_cnt++;
        for (int i = 0; i < m_count(w); i++) begin
            exp_val.push_back(m_sample(w, i));
            exp_base.push_back(k == 1);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (toggle) bus.out_ready = ~bus.out_ready;
    end

    always @(negedge clk) begin
        cyc++;
        if (armed) begin
            check("out_valid", bus.out_valid, exp_val.size() != 0);
            check("in_ready", bus.in_ready,
                  (exp_val.size() == 0) || (bus.out_ready && exp_val.size() == 1));
            if (exp_val.size() != 0 && bus.out_valid) begin
                check("out_sample", bus.out_sample, exp_val[0]);
                check("out_baseline", bus.out_baseline, exp_base[0]);
            end
            check("orbit_pulse", bus.orbit_pulse, exp_orbit);
            check("sync_pulse", bus.sync_pulse, exp_sync);
            check("err_pulse", bus.err_pulse, exp_err);
            check("err_count", bus.err_count, exp_cnt);
            orbit_seen += bus.orbit_pulse;
            sync_seen  += bus.sync_pulse;
            err_seen   += bus.err_pulse;
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_sample);
                got_base.push_back(bus.out_baseline);
                got_cyc.push_back(cyc);
            end
            if (exp_val.size() != 0 && bus.out_ready) begin
                void'(exp_val.pop_front());
                void'(exp_base.pop_front());
            end
        end
        exp_orbit = 0;
        exp_sync  = 0;
        exp_err   = 0;
        if (!reset) begin
            armed = 1'b1;
            exp_val.delete();
            exp_base.delete();
            exp_cnt = 0;
        end else if (armed && bus.in_valid && bus.in_ready) begin
            model_accept(bus.in_data);
        end
    end

    task automatic send(input logic [31:0] w);
        int n = 0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("send_accept", bus.in_ready, 1);
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_val.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain", bus.out_valid, 0);
        @(posedge clk); #2;
    endtask

    task automatic expect_got(input string name, input int e[$]);
        check({name, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++)
            check(name, got[i], e[i]);
    endtask

    task automatic clear_got();
        got.delete();
        got_base.delete();
        got_cyc.delete();
    endtask

    initial begin
        int e[$];
        int s0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_sample", bus.out_sample, 0);
        check("reset_err_count", bus.err_count, 0);

        check("model_b5", m_sample(32'h4510_3081, 3), 4);
        check("model_sig", m_sample(32'h2957_8123, 1), 'hABC);
        check("model_hdr", m_kind(32'h2FC1_E005), 4);
        check("model_sync", m_kind(32'h2D55_4005), 5);
        check("model_n3", m_count(32'h8300_9207), 3);
        check("model_n5", m_count(32'h8510_3081), 0);
        check("model_idle", m_kind(32'hF000_0000), 0);

        clear_got();
        send(32'h4510_3081);
        drain();
        e = '{1, 2, 3, 4, 5};
        expect_got("t1", e);
        check("t1_base", got_base.sum() with (int'(item)), 5);
        if (got_cyc.size() == 5) check("t1_span", got_cyc[4] - got_cyc[0], 4);

        clear_got();
        send(32'h8300_9207);
        send(32'h4510_3081);
        drain();
        e = '{7, 8, 9, 1, 2, 3, 4, 5};
        expect_got("t2", e);
        if (got_cyc.size() == 8) check("t2_no_bubble", got_cyc[3] - got_cyc[2], 1);

        clear_got();
        send(32'h2957_8123);
        drain();
        e = '{'h123, 'hABC};
        expect_got("t3", e);
        if (got_base.size() == 2) check("t3_base", got_base[0] | got_base[1], 0);

        clear_got();
        s0 = orbit_seen;
        send(32'h2FC1_E005);
        drain();
        check("t4_orbit", orbit_seen - s0, 1);
        s0 = sync_seen;
        send(32'h2D55_4005);
        drain();
        check("t4_sync", sync_seen - s0, 1);
        e = '{'h005, 'h005};
        expect_got("t4", e);

        clear_got();
        bus.out_ready = 1'b0;
        toggle = 1'b1;
        send(32'h4510_3081);
        drain();
        toggle = 1'b0;
        #1 bus.out_ready = 1'b1;
        e = '{1, 2, 3, 4, 5};
        expect_got("t5", e);
        if (got_cyc.size() == 5) check("t5_hold", got_cyc[1] - got_cyc[0], 2);

        clear_got();
        s0 = err_seen;
        send(32'h8000_0000);
        send(32'h2C00_0000);
        send(32'hF000_0000);
        drain();
        check("t6_err_pulses", err_seen - s0, 2);
        check("t6_err_count", bus.err_count, 2);
        check("t6_no_samples", got.size(), 0);

        clear_got();
        send(32'h8410_3081);
        send(32'h8510_3081);
        drain();
        e = '{1, 2, 3, 4};
        expect_got("n4", e);
        check("n5_err_count", bus.err_count, 3);

        for (int i = 0; i < 260; i++) send(32'h2C00_0000);
        drain();
        check("err_saturate", bus.err_count, 255);

        send(32'h4510_3081);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_err_count", bus.err_count, 0);

        clear_got();
        send(32'h2957_8123);
        drain();
        e = '{'h123, 'hABC};
        expect_got("post_rst", e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
